// File: rtl/asym_fifo_pkg.sv
// -----------------------------------------------------------------------------
// asym_fifo_pkg
// Shared constants and elaboration-time helpers for the asym_fifo block.
//   DEF_R_WIDTH / DEF_RATIO / DEF_DEPTH : default parameter values
//   is_pow2()                           : power-of-two test
//   params_ok()                         : legality check for the geometry
// -----------------------------------------------------------------------------
package asym_fifo_pkg;

    localparam int DEF_R_WIDTH = 8;
    localparam int DEF_RATIO   = 2;
    localparam int DEF_DEPTH   = 8;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Writes must land on slot-aligned addresses so a wide word never
    // straddles the wrap point; that needs DEPTH to be a multiple of RATIO.
    function automatic bit params_ok(input int r_width, input int ratio, input int depth);
        return (r_width >= 1) && is_pow2(ratio) && is_pow2(depth) &&
               ((depth % ratio) == 0) && (depth >= 2 * ratio);
    endfunction

endpackage

// File: rtl/asym_fifo_if.sv
// -----------------------------------------------------------------------------
// asym_fifo_if
// Producer/consumer bus for asym_fifo.
//   master : the side that pushes wide words and pops narrow words
//   slave  : the FIFO itself
// Signals: wr, w_data (wide), rd, r_data (narrow, fall-through), full, empty,
//          almost_full, almost_empty, count, wr_err, rd_err.
// -----------------------------------------------------------------------------
interface asym_fifo_if
    import asym_fifo_pkg::*;
#(
    parameter int R_WIDTH = DEF_R_WIDTH,
    parameter int RATIO   = DEF_RATIO,
    parameter int DEPTH   = DEF_DEPTH
) ();

    localparam int W_WIDTH = RATIO * R_WIDTH;
    localparam int CW      = $clog2(DEPTH + 1);

    logic               wr;
    logic [W_WIDTH-1:0] w_data;
    logic               rd;
    logic [R_WIDTH-1:0] r_data;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [CW-1:0]      count;
    logic               wr_err;
    logic               rd_err;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, almost_full, almost_empty, count, wr_err, rd_err
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, almost_full, almost_empty, count, wr_err, rd_err
    );

endinterface

// File: rtl/asym_fifo_mem.sv
// -----------------------------------------------------------------------------
// asym_fifo_mem
// Wide-write / narrow-read register file.
//   clk    : clock
//   w_en   : store all RATIO slices of w_data starting at w_addr
//   w_addr : slot-aligned narrow-word address of the first slice
//   w_data : wide word
//   r_addr : narrow-word read address
//   r_data : narrow word at r_addr (combinational, for fall-through reads)
// Slice ordering is resolved here: with LSB_FIRST the least-significant slice
// goes to the lowest address, otherwise the most-significant slice does.
// -----------------------------------------------------------------------------
module asym_fifo_mem
    import asym_fifo_pkg::*;
#(
    parameter int R_WIDTH   = DEF_R_WIDTH,
    parameter int RATIO     = DEF_RATIO,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       w_en,
    input  logic [$clog2(DEPTH)-1:0]   w_addr,
    input  logic [RATIO*R_WIDTH-1:0]   w_data,
    input  logic [$clog2(DEPTH)-1:0]   r_addr,
    output logic [R_WIDTH-1:0]         r_data
);

    localparam int AW = $clog2(DEPTH);

    // The read port is asynchronous: the head word must be visible in the
    // same cycle it becomes the head, so this stays a register file rather
    // than a block RAM with a registered read.
    logic [R_WIDTH-1:0] mem [DEPTH];
    logic [R_WIDTH-1:0] slice_data [RATIO];

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
            localparam int SRC = LSB_FIRST ? gi : (RATIO - 1 - gi);
            assign slice_data[gi] = w_data[SRC*R_WIDTH +: R_WIDTH];
        end
    endgenerate

    // w_addr is a multiple of RATIO, so w_addr + k never crosses the wrap.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int k = 0; k < RATIO; k++) begin
                mem[w_addr + AW'(k)] <= slice_data[k];
            end
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/asym_fifo.sv
// -----------------------------------------------------------------------------
// asym_fifo
// Width-converting FIFO: one wide word in per write, RATIO narrow words out.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : asym_fifo_if.slave
//           wr/w_data      wide write request/data
//           rd             pop the current head (r_data)
//           r_data         head narrow word, 0 while empty
//           full           fewer than RATIO free narrow slots
//           empty          count == 0
//           almost_full    count >= AF_THRESH
//           almost_empty   count <= AE_THRESH
//           count          occupancy in narrow words
//           wr_err/rd_err  one-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
module asym_fifo
    import asym_fifo_pkg::*;
#(
    parameter int R_WIDTH   = DEF_R_WIDTH,
    parameter int RATIO     = DEF_RATIO,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit LSB_FIRST = 1'b1,
    parameter int AF_THRESH = DEPTH - RATIO,
    parameter int AE_THRESH = 1
) (
    input  logic         clk,
    input  logic         reset,
    asym_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (!params_ok(R_WIDTH, RATIO, DEPTH)) begin : g_param_err
            $error("asym_fifo: illegal geometry R_WIDTH=%0d RATIO=%0d DEPTH=%0d",
                   R_WIDTH, RATIO, DEPTH);
        end
    endgenerate

    logic [AW-1:0]      w_ptr_reg, w_ptr_next;
    logic [AW-1:0]      r_ptr_reg, r_ptr_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               wr_err_reg, wr_err_next;
    logic               rd_err_reg, rd_err_next;

    logic               full_flag;
    logic               empty_flag;
    logic               wr_ok;
    logic               rd_ok;
    logic [R_WIDTH-1:0] mem_r_data;

    // Flags come straight from the registered count, so accept decisions
    // always use the pre-edge state: a full FIFO rejects a write even when a
    // read in the same cycle would have freed a slot, and an empty FIFO
    // rejects a read even when a write lands in the same cycle.
    assign full_flag  = (int'(count_reg) > (DEPTH - RATIO));
    assign empty_flag = (count_reg == '0);

    assign wr_ok = bus.wr & ~full_flag;
    assign rd_ok = bus.rd & ~empty_flag;

    always_comb begin
        w_ptr_next  = w_ptr_reg;
        r_ptr_next  = r_ptr_reg;
        count_next  = count_reg;
        wr_err_next = bus.wr & full_flag;
        rd_err_next = bus.rd & empty_flag;

        // DEPTH is a power of two, so the natural wrap of the pointer
        // registers implements the modulo.
        if (wr_ok) begin
            w_ptr_next = w_ptr_reg + AW'(RATIO);
        end
        if (rd_ok) begin
            r_ptr_next = r_ptr_reg + AW'(1);
        end

        // A write is only accepted with at least RATIO free slots, so the
        // intermediate sum never exceeds DEPTH.
        count_next = count_reg
                   + (wr_ok ? CW'(RATIO) : CW'(0))
                   - (rd_ok ? CW'(1)     : CW'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_reg  <= '0;
            r_ptr_reg  <= '0;
            count_reg  <= '0;
            wr_err_reg <= 1'b0;
            rd_err_reg <= 1'b0;
        end else begin
            w_ptr_reg  <= w_ptr_next;
            r_ptr_reg  <= r_ptr_next;
            count_reg  <= count_next;
            wr_err_reg <= wr_err_next;
            rd_err_reg <= rd_err_next;
        end
    end

    asym_fifo_mem #(
        .R_WIDTH   (R_WIDTH),
        .RATIO     (RATIO),
        .DEPTH     (DEPTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_mem (
        .clk    (clk),
        .w_en   (wr_ok),
        .w_addr (w_ptr_reg),
        .w_data (bus.w_data),
        .r_addr (r_ptr_reg),
        .r_data (mem_r_data)
    );

    // Storage is never cleared, so stale contents are masked while empty.
    assign bus.r_data       = empty_flag ? '0 : mem_r_data;
    assign bus.full         = full_flag;
    assign bus.empty        = empty_flag;
    assign bus.almost_full  = (int'(count_reg) >= AF_THRESH);
    assign bus.almost_empty = (int'(count_reg) <= AE_THRESH);
    assign bus.count        = count_reg;
    assign bus.wr_err       = wr_err_reg;
    assign bus.rd_err       = rd_err_reg;

endmodule

// File: tb/tb_asym_fifo.sv
// -----------------------------------------------------------------------------
// tb_asym_fifo
// Two instances share clk/reset: dut_l (LSB slice first) carries most of the
// scenarios against a queue scoreboard; dut_m (MSB slice first) checks the
// reversed slice order.
// -----------------------------------------------------------------------------
module tb_asym_fifo;
    import asym_fifo_pkg::*;

    localparam int RW = 8;
    localparam int RT = 2;
    localparam int DP = 8;
    localparam int AF = DP - RT;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    asym_fifo_if #(.R_WIDTH(RW), .RATIO(RT), .DEPTH(DP)) ifc_l ();
    asym_fifo_if #(.R_WIDTH(RW), .RATIO(RT), .DEPTH(DP)) ifc_m ();

    asym_fifo #(
        .R_WIDTH(RW), .RATIO(RT), .DEPTH(DP), .LSB_FIRST(1'b1),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_l.slave)
    );

    asym_fifo #(
        .R_WIDTH(RW), .RATIO(RT), .DEPTH(DP), .LSB_FIRST(1'b0),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_m.slave)
    );

    // Scoreboard and reference occupancy for dut_l
    logic [7:0] sb_q[$];
    int         model_count = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Results of the last step()
    logic [7:0] got;
    logic [7:0] exp;
    bit         popped;
    bit         exp_werr;
    bit         exp_rerr;

    // One clock of dut_l traffic, called at a falling edge. Updates the
    // scoreboard from the bench's own acceptance rules and returns the head
    // word seen before the edge together with the expected popped word.
    task automatic step(input bit w, input logic [15:0] d, input bit r);
        bit acc_w;
        bit acc_r;
        got      = ifc_l.r_data;
        acc_w    = w && (model_count + RT <= DP);
        acc_r    = r && (model_count > 0);
        popped   = acc_r;
        exp      = 8'h00;
        if (acc_r) exp = sb_q.pop_front();
        if (acc_w) begin
            sb_q.push_back(d[7:0]);
            sb_q.push_back(d[15:8]);
        end
        model_count = model_count + (acc_w ? RT : 0) - (acc_r ? 1 : 0);
        exp_werr = w && !acc_w;
        exp_rerr = r && !acc_r;
        ifc_l.wr     = w;
        ifc_l.w_data = d;
        ifc_l.rd     = r;
        @(posedge clk);
        @(negedge clk);
        ifc_l.wr = 1'b0;
        ifc_l.rd = 1'b0;
        $display("txn wr=%0b w_data=%h rd=%0b popped=%0b head=%h count=%0d wr_err=%0b rd_err=%0b",
                 w, d, r, popped, got, ifc_l.count, ifc_l.wr_err, ifc_l.rd_err);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc_l.wr = 1'b0; ifc_l.rd = 1'b0; ifc_l.w_data = '0;
        ifc_m.wr = 1'b0; ifc_m.rd = 1'b0; ifc_m.w_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        model_count = 0;
        if ({ifc_l.count, ifc_l.empty, ifc_l.full, ifc_l.almost_empty, ifc_l.almost_full,
             ifc_l.wr_err, ifc_l.rd_err, ifc_l.r_data} !== {4'd0, 6'b101000, 8'h00}) begin
            $display("FAIL reset_lsb: got count=%0d e=%0b f=%0b ae=%0b af=%0b we=%0b re=%0b r=%h want 0 1 0 1 0 0 0 00",
                     ifc_l.count, ifc_l.empty, ifc_l.full, ifc_l.almost_empty, ifc_l.almost_full,
                     ifc_l.wr_err, ifc_l.rd_err, ifc_l.r_data);
            n_bad++;
        end
        n_cmp++;
        if ({ifc_m.count, ifc_m.empty, ifc_m.full, ifc_m.r_data} !== {4'd0, 2'b10, 8'h00}) begin
            $display("FAIL reset_msb: got count=%0d e=%0b f=%0b r=%h want 0 1 0 00",
                     ifc_m.count, ifc_m.empty, ifc_m.full, ifc_m.r_data);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_basic_lsb();
        step(1'b1, 16'hA1B2, 1'b0);
        if ({ifc_l.count, ifc_l.empty, ifc_l.r_data} !== {4'd2, 1'b0, 8'hB2}) begin
            $display("FAIL basic_write: got count=%0d empty=%0b r_data=%h want 2 0 b2",
                     ifc_l.count, ifc_l.empty, ifc_l.r_data);
            n_bad++;
        end
        n_cmp++;
        step(1'b0, 16'h0000, 1'b1);
        if (got !== exp) begin
            $display("FAIL basic_pop0: got %h want %h", got, exp); n_bad++;
        end
        n_cmp++;
        if ({ifc_l.count, ifc_l.r_data} !== {4'd1, 8'hA1}) begin
            $display("FAIL basic_read1: got count=%0d r_data=%h want 1 a1", ifc_l.count, ifc_l.r_data);
            n_bad++;
        end
        n_cmp++;
        step(1'b0, 16'h0000, 1'b1);
        if (got !== exp) begin
            $display("FAIL basic_pop1: got %h want %h", got, exp); n_bad++;
        end
        n_cmp++;
        if ({ifc_l.count, ifc_l.empty, ifc_l.almost_empty, ifc_l.r_data} !== {4'd0, 2'b11, 8'h00}) begin
            $display("FAIL basic_drained: got count=%0d empty=%0b ae=%0b r_data=%h want 0 1 1 00",
                     ifc_l.count, ifc_l.empty, ifc_l.almost_empty, ifc_l.r_data);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_msb_first();
        logic [7:0] want [2];
        want[0] = 8'hA1;
        want[1] = 8'hB2;
        ifc_m.wr = 1'b1; ifc_m.w_data = 16'hA1B2;
        @(posedge clk); @(negedge clk);
        ifc_m.wr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            $display("txn msb head=%h count=%0d", ifc_m.r_data, ifc_m.count);
            if (ifc_m.r_data !== want[i]) begin
                $display("FAIL msb_slice%0d: got %h want %h", i, ifc_m.r_data, want[i]); n_bad++;
            end
            n_cmp++;
            ifc_m.rd = 1'b1;
            @(posedge clk); @(negedge clk);
            ifc_m.rd = 1'b0;
        end
        if ({ifc_m.empty, ifc_m.r_data} !== {1'b1, 8'h00}) begin
            $display("FAIL msb_drained: got empty=%0b r_data=%h want 1 00", ifc_m.empty, ifc_m.r_data);
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h1020 + 16'(i * 16'h0303), 1'b0);
        if ({ifc_l.count, ifc_l.full, ifc_l.almost_full} !== {4'd8, 2'b11}) begin
            $display("FAIL fill_full: got count=%0d full=%0b af=%0b want 8 1 1",
                     ifc_l.count, ifc_l.full, ifc_l.almost_full);
            n_bad++;
        end
        n_cmp++;
        step(1'b1, 16'hDEAD, 1'b0);
        if ({ifc_l.count, ifc_l.wr_err} !== {4'd8, exp_werr}) begin
            $display("FAIL fill_overflow: got count=%0d wr_err=%0b want 8 %0b", ifc_l.count, ifc_l.wr_err, exp_werr);
            n_bad++;
        end
        n_cmp++;
        step(1'b0, 16'h0000, 1'b0);
        if (ifc_l.wr_err !== 1'b0) begin
            $display("FAIL fill_err_pulse: got wr_err=%0b want 0", ifc_l.wr_err); n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0000, 1'b1);
            if (!popped || got !== exp) begin
                $display("FAIL fill_drain%0d: got %h want %h (popped=%0b)", i, got, exp, popped); n_bad++;
            end
            n_cmp++;
        end
        if (ifc_l.empty !== 1'b1) begin
            $display("FAIL fill_empty: got empty=%0b want 1", ifc_l.empty); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h4050 + 16'(i), 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        if ({ifc_l.count, ifc_l.full} !== {4'd7, 1'b1}) begin
            $display("FAIL simul_at7: got count=%0d full=%0b want 7 1", ifc_l.count, ifc_l.full); n_bad++;
        end
        n_cmp++;
        step(1'b1, 16'hBEEF, 1'b1);
        if ({got, ifc_l.count, ifc_l.wr_err, ifc_l.rd_err} !== {exp, 4'd6, 2'b10}) begin
            $display("FAIL simul_full: got head=%h count=%0d wr_err=%0b rd_err=%0b want %h 6 1 0",
                     got, ifc_l.count, ifc_l.wr_err, ifc_l.rd_err, exp);
            n_bad++;
        end
        n_cmp++;
        repeat (2) step(1'b0, 16'h0000, 1'b1);
        step(1'b1, 16'hC0DE, 1'b1);
        if ({ifc_l.count, ifc_l.wr_err} !== {4'd5, 1'b0}) begin
            $display("FAIL simul_mid: got count=%0d wr_err=%0b want 5 0", ifc_l.count, ifc_l.wr_err); n_bad++;
        end
        n_cmp++;
        while (model_count > 0) begin
            step(1'b0, 16'h0000, 1'b1);
            if (got !== exp) begin
                $display("FAIL simul_drain: got %h want %h", got, exp); n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_rd_empty();
        step(1'b0, 16'h0000, 1'b1);
        if ({ifc_l.rd_err, ifc_l.count, ifc_l.empty} !== {exp_rerr, 4'd0, 1'b1}) begin
            $display("FAIL rdempty_err: got rd_err=%0b count=%0d empty=%0b want 1 0 1",
                     ifc_l.rd_err, ifc_l.count, ifc_l.empty);
            n_bad++;
        end
        n_cmp++;
        step(1'b0, 16'h0000, 1'b0);
        if (ifc_l.rd_err !== 1'b0) begin
            $display("FAIL rdempty_pulse: got rd_err=%0b want 0", ifc_l.rd_err); n_bad++;
        end
        n_cmp++;
        step(1'b1, 16'h1234, 1'b1);
        if ({ifc_l.rd_err, ifc_l.count, ifc_l.r_data} !== {1'b1, 4'd2, 8'h34}) begin
            $display("FAIL rdempty_wr_rd: got rd_err=%0b count=%0d r_data=%h want 1 2 34",
                     ifc_l.rd_err, ifc_l.count, ifc_l.r_data);
            n_bad++;
        end
        n_cmp++;
        repeat (2) begin
            step(1'b0, 16'h0000, 1'b1);
            if (got !== exp) begin
                $display("FAIL rdempty_drain: got %h want %h", got, exp); n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_wrap_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 16'($urandom_range(0, 65535)), i > 0);
            if (popped && got !== exp) begin
                $display("FAIL wrap_wr_pop%0d: got %h want %h", i, got, exp); n_bad++;
            end
            if (ifc_l.count !== 4'(model_count)) begin
                $display("FAIL wrap_count%0d: got %0d want %0d", i, ifc_l.count, model_count); n_bad++;
            end
            n_cmp++;
            step(1'b0, 16'h0000, 1'b1);
            if (!popped || got !== exp) begin
                $display("FAIL wrap_pop%0d: got %h want %h (popped=%0b)", i, got, exp, popped); n_bad++;
            end
            n_cmp++;
        end
        step(1'b0, 16'h0000, 1'b1);
        if (!popped || got !== exp || ifc_l.empty !== 1'b1) begin
            $display("FAIL wrap_last: got %h empty=%0b want %h empty=1", got, ifc_l.empty, exp); n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) step(1'b1, 16'h7788 + 16'(i), 1'b0);
        if (ifc_l.count !== 4'd6) begin
            $display("FAIL wrap_pre_reset: got count=%0d want 6", ifc_l.count); n_bad++;
        end
        n_cmp++;
        // Reset with both requests asserted: they must be ignored.
        ifc_l.wr = 1'b1; ifc_l.rd = 1'b1; ifc_l.w_data = 16'hFFFF;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        ifc_l.wr = 1'b0; ifc_l.rd = 1'b0;
        sb_q.delete();
        model_count = 0;
        $display("txn reset count=%0d head=%h", ifc_l.count, ifc_l.r_data);
        if ({ifc_l.count, ifc_l.empty, ifc_l.full, ifc_l.almost_empty, ifc_l.almost_full,
             ifc_l.wr_err, ifc_l.rd_err, ifc_l.r_data} !== {4'd0, 6'b101000, 8'h00}) begin
            $display("FAIL midreset: got count=%0d e=%0b f=%0b ae=%0b af=%0b we=%0b re=%0b r=%h want 0 1 0 1 0 0 0 00",
                     ifc_l.count, ifc_l.empty, ifc_l.full, ifc_l.almost_empty, ifc_l.almost_full,
                     ifc_l.wr_err, ifc_l.rd_err, ifc_l.r_data);
            n_bad++;
        end
        n_cmp++;
        step(1'b0, 16'h0000, 1'b0);
        if ({ifc_l.wr_err, ifc_l.rd_err, ifc_l.count} !== {2'b00, 4'd0}) begin
            $display("FAIL midreset_quiet: got wr_err=%0b rd_err=%0b count=%0d want 0 0 0",
                     ifc_l.wr_err, ifc_l.rd_err, ifc_l.count);
            n_bad++;
        end
        n_cmp++;
        step(1'b1, 16'h5A6B, 1'b0);
        if ({ifc_l.count, ifc_l.r_data} !== {4'd2, 8'h6B}) begin
            $display("FAIL postreset_write: got count=%0d r_data=%h want 2 6b", ifc_l.count, ifc_l.r_data);
            n_bad++;
        end
        n_cmp++;
        repeat (2) begin
            step(1'b0, 16'h0000, 1'b1);
            if (got !== exp) begin
                $display("FAIL postreset_pop: got %h want %h", got, exp); n_bad++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_lsb();
        test_msb_first();
        test_fill();
        test_simultaneous();
        test_rd_empty();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/asym_fifo.md
# asym_fifo

Parameterised width-converting FIFO: accepts one wide word per write and returns it as RATIO narrow slices, in a configurable slice order. Depth, narrow width, ratio and watermark thresholds are set by parameters. The block adds an occupancy count, almost-full/almost-empty watermarks and overflow/underflow error pulses. It sits between a wide producer (e.g. 16-bit sample path) and a narrow consumer (e.g. 8-bit UART/display path).

## Interface
- R_WIDTH, 8, narrow (read) word width in bits
- RATIO, 2, write/read width ratio; W_WIDTH = RATIO*R_WIDTH; power of 2, ≥1
- DEPTH, 8, capacity in narrow words; power of 2, multiple of RATIO, ≥ 2*RATIO
- LSB_FIRST, 1, 1: slice [R_WIDTH-1:0] read first; 0: most-significant slice first
- AF_THRESH, DEPTH-RATIO, almost_full asserted when count ≥ AF_THRESH
- AE_THRESH, 1, almost_empty asserted when count ≤ AE_THRESH

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr  in  1  write request
- w_data  in  W_WIDTH  wide write word
- rd  in  1  read request (pops current r_data)
- r_data  out  R_WIDTH  head narrow word (first-word fall-through)
- full  out  1  free space < RATIO
- empty  out  1  count == 0
- almost_full  out  1  watermark
- almost_empty  out  1  watermark
- count  out  $clog2(DEPTH+1)  occupancy in narrow words
- wr_err  out  1  one-cycle pulse: previous-cycle write rejected
- rd_err  out  1  one-cycle pulse: previous-cycle read rejected

## Operation
- Accept conditions, evaluated on current registered state: wr_ok = wr & ~full; rd_ok = rd & ~empty.
- Accepted write stores RATIO slices at w_ptr..w_ptr+RATIO-1; w_ptr advances by RATIO mod DEPTH. Writes always slot-aligned (DEPTH multiple of RATIO), never split across wrap.
- Slice order: LSB_FIRST=1 → slice k = w_data[k*R_WIDTH +: R_WIDTH] at w_ptr+k; LSB_FIRST=0 → slice order reversed.
- Accepted read advances r_ptr by 1 mod DEPTH.
- count_next = count + (wr_ok ? RATIO : 0) − (rd_ok ? 1 : 0); both may occur in one cycle.
- full/empty/watermarks decoded combinationally from registered count.
- Rejected write: storage, w_ptr, count unchanged; wr_err = 1 next cycle. Rejected read: r_ptr, count unchanged; rd_err = 1 next cycle.
- r_data = mem[r_ptr] when ~empty; driven 0 when empty.
- No state machine beyond pointer/count registers.

## Timing
- Reset values: w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), wr_err=0, rd_err=0, r_data=0. Storage not reset.
- Reset mid-operation: contents discarded; next cycle shows reset values; wr/rd in reset cycle ignored, no error pulses.
- Write-to-read latency: word written at edge N is visible on r_data (empty=0) after edge N.
- Read: r_data updates to next slice after the edge where rd_ok.
- Full with simultaneous wr+rd: write rejected (full uses pre-read state), read accepted.
- Empty with simultaneous wr+rd: read rejected (rd_err), write accepted.
- Error pulses last exactly one cycle per rejected request.

## Structure
- Package asym_fifo_pkg: default parameter constants (R_WIDTH/RATIO/DEPTH defaults) and a compile-time parameter check function (power-of-2, DEPTH % RATIO == 0).
- Sub-module asym_fifo_mem: wide-write/narrow-read register file (w_en, w_addr, w_data, r_addr, r_data), slice ordering applied here.
- Top asym_fifo: pointers, count, flags, error pulses.
- Elaboration-time $error on illegal parameters.

## Test plan
- Defaults, LSB_FIRST=1: reset, write 0xA1B2 → count=2, empty=0, r_data=0xB2; rd → 0xA1, count=1; rd → empty=1, count=0, r_data=0.
- LSB_FIRST=0: write 0xA1B2 → reads 0xA1 then 0xB2.
- Fill: 4 writes → count=8, full=1, almost_full=1; 5th write → count stays 8, wr_err=1 for one cycle, then 8 reads return data in order.
- count=7 (full), wr+rd same cycle → write rejected, wr_err pulse, count=6; count=4, wr+rd → count=5.
- rd while empty → rd_err one-cycle pulse, r_ptr unchanged; then write 0x1234 → r_data=0x34.
- Wrap and reset: 12 writes / 24 reads interleaved, scoreboard order across pointer wrap; at count=6 assert reset → next cycle all outputs at reset values, prior data never reappears.
